// File: rtl/dsp_mac_pkg.sv
// Shared widths and record types for the dual 8-bit MAC streaming controller.
package dsp_mac_pkg;
    localparam int OP_W  = 8;
    localparam int RES_W = 27;
    localparam int LEN_W = 8;

    typedef struct packed {
        logic [OP_W-1:0] a1;
        logic [OP_W-1:0] b1;
        logic [OP_W-1:0] a2;
        logic [OP_W-1:0] b2;
        logic            last;
    } op_pair_t;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [LEN_W-1:0] len;
    } res_t;
endpackage

// File: rtl/dsp_mac_8bit_dot_ctrl_fifo.sv
// Show-ahead synchronous FIFO; simultaneous push/pop is legal even when full.
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dsp_mac_8bit_dot_ctrl.sv
// Streaming front/back end for the dual 8-bit MAC: feeds operand pairs, tracks
// pipeline latency with a tag pipe, and queues finished dot-products.
module dsp_mac_8bit_dot_ctrl
    import dsp_mac_pkg::*;
#(
    parameter int MAC_LAT   = 3,
    parameter int OUT_DEPTH = 4,
    parameter int LEN_W     = dsp_mac_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a1,
    input  logic [OP_W-1:0]  in_b1,
    input  logic [OP_W-1:0]  in_a2,
    input  logic [OP_W-1:0]  in_b2,
    input  logic             in_last,
    output logic [OP_W-1:0]  mac_ax,
    output logic [OP_W-1:0]  mac_bx,
    output logic [OP_W-1:0]  mac_ay,
    output logic [OP_W-1:0]  mac_by,
    output logic             mac_accumulate,
    input  logic [RES_W-1:0] mac_resulta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [LEN_W-1:0] out_len
);
    localparam int NT = MAC_LAT + 1;
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_INIT = CW'(OUT_DEPTH);

    typedef struct packed {
        logic             last;
        logic [LEN_W-1:0] len;
    } tag_t;

    op_pair_t         in_pair;
    tag_t             tags [NT];
    logic [CW-1:0]    credits;
    logic             first;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_nxt;
    logic             accept;
    logic             last_acc;
    logic             fifo_push;
    logic             fifo_pop;
    res_t             fifo_wdata;
    res_t             fifo_rdata;

    assign in_pair   = {in_a1, in_b1, in_a2, in_b2, in_last};
    assign in_ready  = (credits != '0) && !reset;
    assign accept    = in_valid && in_ready;
    assign last_acc  = accept && in_pair.last;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = tags[NT-1].last;
    assign len_nxt   = first ? LEN_W'(1) : ((&len_cnt) ? len_cnt : len_cnt + LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mac_ax         <= '0;
            mac_bx         <= '0;
            mac_ay         <= '0;
            mac_by         <= '0;
            mac_accumulate <= 1'b0;
            first          <= 1'b1;
            len_cnt        <= '0;
            credits        <= CREDIT_INIT;
            for (int i = 0; i < NT; i++) tags[i] <= '0;
        end else begin
            if (accept) begin
                mac_ax         <= in_pair.a1;
                mac_bx         <= in_pair.b1;
                mac_ay         <= in_pair.a2;
                mac_by         <= in_pair.b2;
                mac_accumulate <= !first;
                first          <= in_pair.last;
                len_cnt        <= len_nxt;
            end else begin
                // Bubbles add zero while holding the running sum.
                mac_ax         <= '0;
                mac_bx         <= '0;
                mac_ay         <= '0;
                mac_by         <= '0;
                mac_accumulate <= 1'b1;
            end
            tags[0] <= '{last: last_acc, len: len_nxt};
            for (int i = 1; i < NT; i++) tags[i] <= tags[i-1];
            case ({last_acc, fifo_pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign fifo_wdata = '{data: mac_resulta, len: tags[NT-1].len};

    sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .valid (out_valid)
    );

    assign out_data = fifo_rdata.data;
    assign out_len  = fifo_rdata.len;
endmodule

// File: tb/tb_dsp_mac_8bit_dot_ctrl.sv
// Bench for dsp_mac_8bit_dot_ctrl with a behavioural 3-cycle MAC and a result scoreboard.
module tb_dsp_mac_8bit_dot_ctrl;
    localparam int MAC_LAT   = 3;
    localparam int OUT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a1, in_b1, in_a2, in_b2;
    logic        in_last;
    logic [7:0]  mac_ax, mac_bx, mac_ay, mac_by;
    logic        mac_accumulate;
    logic [26:0] mac_resulta = '0;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_data;
    logic [7:0]  out_len;

    always #5 clk = ~clk;

    dsp_mac_8bit_dot_ctrl #(.MAC_LAT(MAC_LAT), .OUT_DEPTH(OUT_DEPTH), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a1(in_a1), .in_b1(in_b1), .in_a2(in_a2), .in_b2(in_b2), .in_last(in_last),
        .mac_ax(mac_ax), .mac_bx(mac_bx), .mac_ay(mac_ay), .mac_by(mac_by),
        .mac_accumulate(mac_accumulate), .mac_resulta(mac_resulta),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
    );

    // Behavioural MAC: accumulator updates one edge after the operands, then two delay stages.
    logic [26:0] m_acc = '0;
    logic [26:0] m_d1  = '0;
    always @(posedge clk) begin
        m_acc       <= (mac_accumulate ? m_acc : 27'd0)
                       + 27'(mac_ax) * 27'(mac_bx) + 27'(mac_ay) * 27'(mac_by);
        m_d1        <= m_acc;
        mac_resulta <= m_d1;
    end

    typedef struct {
        logic [26:0] data;
        logic [7:0]  len;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  a1, b1, a2, b2;
        logic        last;
        logic        exp_acc;
        logic [26:0] exp_data;
        logic [7:0]  exp_len;
    } vec_t;
    vec_t tv[7];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_res(input logic [26:0] d, input logic [7:0] l);
        exp_t e;
        e.data = d;
        e.len  = l;
        sb.push_back(e);
    endtask

    // Observe handshakes mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (dut.fifo_push)
            check("fifo_no_overflow", 32'(dut.u_fifo.full && !dut.fifo_pop), 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_len", 32'(out_len), 32'(e.len));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a1, b1, a2, b2, input logic last);
        in_valid = 1'b1;
        in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2; in_last = last;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        int lat;
        int acc_cnt;
        int w;

        tv[0] = '{8'd1,   8'd2,   8'd3,   8'd4,   1'b0, 1'b0, 27'd0,      8'd0};
        tv[1] = '{8'd5,   8'd6,   8'd7,   8'd8,   1'b0, 1'b1, 27'd0,      8'd0};
        tv[2] = '{8'd2,   8'd2,   8'd2,   8'd2,   1'b1, 1'b1, 27'd108,    8'd3};
        tv[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 27'd130050, 8'd1};
        tv[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 27'd0,      8'd0};
        tv[5] = '{8'd7,   8'd9,   8'd1,   8'd1,   1'b1, 1'b1, 27'd64,     8'd2};
        tv[6] = '{8'd10,  8'd20,  8'd30,  8'd40,  1'b1, 1'b0, 27'd1400,   8'd1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a1 = '0; in_b1 = '0; in_a2 = '0; in_b2 = '0; in_last = 1'b0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_len", 32'(out_len), 0);
        check("rst_mac_ax", 32'(mac_ax), 0);
        check("rst_mac_acc", 32'(mac_accumulate), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Back-to-back three-pair vector and result latency.
        drive(8'd1, 8'd2, 8'd3, 8'd4, 1'b0); tick();
        drive(8'd5, 8'd6, 8'd7, 8'd8, 1'b0); tick();
        drive(8'd2, 8'd2, 8'd2, 8'd2, 1'b1); expect_res(27'd108, 8'd3); tick();
        in_valid = 1'b0;
        check("lat_ov_at_accept", 32'(out_valid), 0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (out_valid && lat == 0) lat = k;
        end
        check("latency", 32'(lat), MAC_LAT + 1);
        check("lat_sb_empty", 32'(sb.size()), 0);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            drive(tv[i].a1, tv[i].b1, tv[i].a2, tv[i].b2, tv[i].last);
            w = 0;
            while (!in_ready && w < 20) begin
                tick();
                w++;
            end
            check("tv_ready_wait", 32'(in_ready), 1);
            if (tv[i].last) expect_res(tv[i].exp_data, tv[i].exp_len);
            tick();
            check($sformatf("tv%0d_mac_ax", i), 32'(mac_ax), 32'(tv[i].a1));
            check($sformatf("tv%0d_mac_by", i), 32'(mac_by), 32'(tv[i].b2));
            check($sformatf("tv%0d_mac_acc", i), 32'(mac_accumulate), 32'(tv[i].exp_acc));
        end
        in_valid = 1'b0;
        drain();

        // Bubbles between pairs of a 4-pair vector.
        for (int i = 0; i < 4; i++) begin
            drive(8'd1, 8'd1, 8'd1, 8'd1, i == 3);
            if (i == 3) expect_res(27'd8, 8'd4);
            tick();
            in_valid = 1'b0;
            tick();
            check("bubble_mac_ax", 32'(mac_ax), 0);
            check("bubble_mac_acc", 32'(mac_accumulate), 1);
        end
        drain();

        // Backpressure: only OUT_DEPTH single-pair vectors fit.
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < OUT_DEPTH + 1; i++) begin
            drive(8'(i + 1), 8'd1, 8'd0, 8'd0, 1'b1);
            if (in_ready) begin
                expect_res(27'(i + 1), 8'd1);
                acc_cnt++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc_cnt), OUT_DEPTH);
        check("bp_in_ready_low", 32'(in_ready), 0);
        for (int k = 0; k < 6; k++) tick();
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_still_blocked", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_reenabled", 32'(in_ready), 1);
        drain();

        // Pop and last-accept in the same cycle with one credit left.
        out_ready = 1'b0;
        for (int i = 0; i < OUT_DEPTH - 1; i++) begin
            drive(8'(i + 4), 8'd1, 8'd0, 8'd0, 1'b1);
            expect_res(27'(i + 4), 8'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("sim_one_credit", 32'(in_ready), 1);
        out_ready = 1'b1;
        drive(8'd20, 8'd1, 8'd0, 8'd0, 1'b1);
        expect_res(27'd20, 8'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("sim_ready_after", 32'(in_ready), 1);
        tick();
        check("sim_ready_hold", 32'(in_ready), 1);
        drain();

        // Reset one cycle after a last accept discards that vector.
        drive(8'd9, 8'd9, 8'd9, 8'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_in_ready", 32'(in_ready), 0);
        tick();
        check("mid_rst_mac_ax", 32'(mac_ax), 0);
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_rst_no_out", 32'(out_valid), 0);
        end
        drive(8'd3, 8'd3, 8'd0, 8'd0, 1'b1);
        expect_res(27'd9, 8'd1);
        tick();
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dsp_mac_8bit_dot_ctrl.md
Name: dsp_mac_8bit_dot_ctrl

Overview:
- Streaming front/back end for the dual 8-bit DSP MAC (`dsp_mac_8bit`): result = ax*bx + ay*by, optionally added to the previous result.
- Accepts operand pairs over a valid/ready stream and drives the MAC operand and accumulate controls.
- Tracks MAC pipeline latency and captures each completed dot-product from `resulta` into an output FIFO, emitted on a valid/ready stream with its length.
- Credit-based backpressure ensures a completed result is never dropped.

Parameters:
- MAC_LAT, 3, cycles from MAC operand/accumulate registers updating to `mac_resulta` reflecting them.
- OUT_DEPTH, 4, output FIFO entries (power of 2, >=2).
- LEN_W, 8, width of the per-vector pair counter.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  operand pair accepted when in_valid && in_ready.
- in_a1, in_b1, in_a2, in_b2  input  8 each  unsigned operands; the product is a1*b1 + a2*b2.
- in_last  input  1  marks the final pair of a vector.
- mac_ax, mac_bx, mac_ay, mac_by  output  8 each  registered MAC operands.
- mac_accumulate  output  1  registered MAC accumulate enable.
- mac_resulta  input  27  MAC result.
- out_valid  output  1  result available.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  27  dot-product result, modulo 2^27.
- out_len  output  LEN_W  number of pairs in the vector; saturates at 2^LEN_W-1.

Behaviour:
- Reset values:
  - mac_* operands = 0; mac_accumulate = 0; out_valid = 0; out_data = 0; out_len = 0; in_ready = 0 while reset is high.
  - Internally: FIFO empty, tag pipe cleared, credits = OUT_DEPTH, first = 1, len counter = 0.
  - Reset mid-operation discards every in-flight and queued vector.
- Accept cycle:
  - mac_ax/bx/ay/by <= in_a1/b1/a2/b2.
  - mac_accumulate <= !first.
  - first <= in_last.
  - Len counter: if first, loaded to 1; otherwise incremented, saturating.
- Idle cycle (no accept): mac operands <= 0 and mac_accumulate <= 1, so bubbles add zero and hold the running sum.
- Tag pipe:
  - MAC_LAT+1 stages carrying {last, len}, shifted every cycle.
  - Stage 0 is loaded with {in_last && accept, len value}.
  - When a last tag exits, mac_resulta and its len are written to the FIFO on that edge.
  - Net latency: the accepting edge of a last pair is edge t; the FIFO write is edge t+MAC_LAT+1; out_valid is high after that edge.
- Credits:
  - in_ready = (credits != 0) && !reset.
  - Accepting a last pair decrements credits; an output pop increments them; both in the same cycle leave credits unchanged.
  - Non-last pairs also require credits != 0.
  - FIFO overflow is impossible by construction; the bench asserts on a push while full.
- FIFO:
  - Show-ahead: out_data/out_len are valid whenever out_valid is high.
  - Push and pop in the same cycle are legal, including when full or when it holds exactly 1 entry.
  - Pop on empty is ignored.
- Arithmetic: unsigned throughout; wrap-around beyond 27 bits is the MAC's and is passed through unchanged.
- A single-pair vector (first && in_last) is legal: mac_accumulate = 0 and len = 1.

Decomposition:
- Package dsp_mac_pkg:
  - constants OP_W=8, RES_W=27.
  - typedef op_pair_t {a1, b1, a2, b2, last}.
  - typedef res_t {data[RES_W], len}.
- Sub-module sync_fifo (parameterised width/depth, show-ahead, clk/reset) holds res_t.
- Tag pipe and credit logic stay in the top module.

Test Plan:
- Vector (1,2,3,4),(5,6,7,8),(2,2,2,2)last back-to-back, out_ready=1 -> out_data=108, out_len=3, out_valid high exactly MAC_LAT+1 edges after the last accept.
- Single pair (255,255,255,255) last -> mac_accumulate=0 on that cycle; out_data=130050, out_len=1.
- in_valid toggled 1/0 across a 4-pair vector of (1,1,1,1) -> bubbles insert zero operands with accumulate=1; out_data=8, out_len=4.
- out_ready=0 while OUT_DEPTH+1 single-pair vectors are offered -> exactly OUT_DEPTH accepted, in_ready=0 afterwards; one pop re-enables in_ready on the next cycle; results emerge in order with no loss.
- Simultaneous pop and last-accept at credits=1 -> credits stays 1 and in_ready stays high.
- Reset asserted 1 cycle after a last accept -> no out_valid ever appears for that vector; next vector (3,3,0,0)last -> out_data=9, out_len=1.
